// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit common-anode seven-segment scan controller
//
// Purpose:
//   Holds four hex digits (plus per-digit blank and decimal point) and scans
//   them onto a common-anode display one digit slot at a time. New contents
//   arrive over a valid/ready load port, are parked in a pending buffer and
//   only become visible at a frame boundary, so a frame never mixes old and
//   new digits. Each slot begins with GUARD cycles of all anodes off to
//   suppress ghosting while segment lines settle.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   load_valid   new display contents offered
//   load_ready   block can accept a load (no load pending)
//   load_digits  four hex nibbles, [3:0] -> an[0] ... [15:12] -> an[3]
//   load_blank   per-digit blank, 1 = digit dark
//   load_dp      per-digit decimal point, 1 = dp lit
//   seg          segments {g,f,e,d,c,b,a}, active-low, registered
//   dp           decimal point, active-low, registered
//   an           anodes, active-low, at most one low, registered

module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_digits,
    input  logic [3:0]  load_blank,
    input  logic [3:0]  load_dp,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(REFRESH_DIV - 1);

    // Slot timing
    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    // Contents currently being scanned
    logic [15:0]   act_digits_q, act_digits_d;
    logic [3:0]    act_blank_q, act_blank_d;
    logic [3:0]    act_dp_q, act_dp_d;

    // Contents waiting for the next frame boundary
    logic [15:0]   pend_digits_q, pend_digits_d;
    logic [3:0]    pend_blank_q, pend_blank_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_q, pend_d;

    // Registered pin drivers
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          presc_wrap;
    logic          frame_end;
    logic          accept;
    logic          in_guard;
    logic          slot_dark;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // With GUARD == 0 there is no guard window at all; building the compare
    // would only produce a constant-false comparison.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
            assign in_guard = (presc_q < GUARD_C);
        end
    endgenerate

    // Ready is simply "nothing pending": a second load must wait until the
    // first has been committed to the active set.
    assign load_ready = ~pend_q;

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        frame_end  = presc_wrap && (idx_q == 2'd3);
        accept     = load_valid && !pend_q;

        presc_d = presc_wrap ? '0 : presc_q + CW'(1);
        idx_d   = presc_wrap ? idx_q + 2'd1 : idx_q;

        act_digits_d  = act_digits_q;
        act_blank_d   = act_blank_q;
        act_dp_d      = act_dp_q;
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_dp_d     = pend_dp_q;
        pend_d        = pend_q;

        // Commit and accept are mutually exclusive: accept needs pend_q == 0
        // while commit needs pend_q == 1. A load taken on the boundary cycle
        // therefore waits for the following boundary.
        if (frame_end && pend_q) begin
            act_digits_d = pend_digits_q;
            act_blank_d  = pend_blank_q;
            act_dp_d     = pend_dp_q;
            pend_d       = 1'b0;
        end

        if (accept) begin
            pend_digits_d = load_digits;
            pend_blank_d  = load_blank;
            pend_dp_d     = load_dp;
            pend_d        = 1'b1;
        end

        // Outputs reflect the present slot state and appear one cycle later.
        slot_dark = in_guard || act_blank_q[idx_q];
        if (slot_dark) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(act_digits_q[{idx_q, 2'b00} +: 4]);
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            act_digits_q  <= 16'h0000;
            act_blank_q   <= 4'b1111;
            act_dp_q      <= 4'b0000;
            pend_digits_q <= 16'h0000;
            pend_blank_q  <= 4'b1111;
            pend_dp_q     <= 4'b0000;
            pend_q        <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            act_digits_q  <= act_digits_d;
            act_blank_q   <= act_blank_d;
            act_dp_q      <= act_dp_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_dp_q     <= pend_dp_d;
            pend_q        <= pend_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int RD = 4;
    localparam int G  = 1;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_digits = 16'h0000;
    logic [3:0]  load_blank = 4'b0000;
    logic [3:0]  load_dp = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_digits(load_digits), .load_blank(load_blank), .load_dp(load_dp),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: time since reset determines slot and phase; the
    // display set is a "shown" record plus at most one waiting record.
    int          t = 0;
    int          out_t = -1;
    int          m_ph, m_slot;
    bit          mvalid = 0;
    bit          m_pend = 0;
    bit          was_pend;
    int          acc_cnt = 0;
    logic [15:0] m_dig = 16'h0, p_dig = 16'h0;
    logic [3:0]  m_blank = 4'hF, p_blank = 4'hF, m_dp = 4'h0, p_dp = 4'h0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1, exp_ready = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            t = 0; out_t = -1; m_pend = 0;
            m_dig = 16'h0; m_blank = 4'hF; m_dp = 4'h0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            mvalid = 1;
        end else begin
            m_ph   = t % RD;
            m_slot = (t / RD) % 4;
            if (m_ph < G || m_blank[m_slot]) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an  = 4'hF & ~(4'(1) << m_slot);
                exp_seg = HEX[m_dig[m_slot*4 +: 4]];
                exp_dp  = ~m_dp[m_slot];
            end
            out_t = t;
            was_pend = m_pend;
            if ((t % FR) == FR - 1 && was_pend) begin
                m_dig = p_dig; m_blank = p_blank; m_dp = p_dp; m_pend = 0;
            end
            if (load_valid && !was_pend) begin
                p_dig = load_digits; p_blank = load_blank; p_dp = load_dp;
                m_pend = 1; acc_cnt++;
            end
            t++;
        end
        exp_ready = !m_pend;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting at %0t", nm, $time);
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("an", {28'h0, an}, {28'h0, exp_an});
            chk("seg", {25'h0, seg}, {25'h0, exp_seg});
            chk("dp", {31'h0, dp}, {31'h0, exp_dp});
            chk("load_ready", {31'h0, load_ready}, {31'h0, exp_ready});
            chk("onehot_an", {31'h0, ($countones(~an) <= 1)}, 32'h1);
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic frame_start;
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            tick;
            if (out_t >= 0 && (out_t % FR) == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("frame_start");
    endtask

    task automatic wait_ready;
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (!m_pend) begin
                ok = 1;
                break;
            end
            tick;
        end
        if (!ok) timeout("wait_ready");
    endtask

    // Literal check of one whole frame; slot s uses ans[4s+:4], segs[7s+:7], dps[s].
    task automatic check_frame(input string nm, input logic [15:0] ans,
                               input logic [27:0] segs, input logic [3:0] dps);
        int sl;
        frame_start;
        for (int c = 0; c < FR; c++) begin
            if (c > 0) tick;
            sl = c / RD;
            if ((c % RD) < G) begin
                chk({nm, "_an"}, {28'h0, an}, 32'hF);
                chk({nm, "_seg"}, {25'h0, seg}, 32'h7F);
                chk({nm, "_dp"}, {31'h0, dp}, 32'h1);
            end else begin
                chk({nm, "_an"}, {28'h0, an}, {28'h0, ans[sl*4 +: 4]});
                chk({nm, "_seg"}, {25'h0, seg}, {25'h0, segs[sl*7 +: 7]});
                chk({nm, "_dp"}, {31'h0, dp}, {31'h0, dps[sl]});
            end
        end
    endtask

    localparam logic [27:0] SEG_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [27:0] SEG_ABCD = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
    localparam logic [27:0] SEG_DARK = {4{7'b1111111}};

    int base;
    bit ok;

    initial begin
        // 1. reset and dark display
        rst = 1'b1;
        repeat (3) tick;
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp", {31'h0, dp}, 32'h1);
        chk("rst_ready", {31'h0, load_ready}, 32'h1);
        rst = 1'b0;
        repeat (3) check_frame("dark", 16'hFFFF, SEG_DARK, 4'hF);

        // 2/3. single load, guard timing
        load_valid = 1'b1; load_digits = 16'h1234; load_blank = 4'h0; load_dp = 4'h0;
        tick;
        load_valid = 1'b0;
        chk("t2_ready_low", {31'h0, load_ready}, 32'h0);
        frame_start;
        check_frame("t2", 16'h7BDE, SEG_1234, 4'hF);
        chk("t2_ready_high", {31'h0, load_ready}, 32'h1);

        // 4. back-to-back loads, second held until accepted
        wait_ready;
        base = acc_cnt;
        load_valid = 1'b1; load_digits = 16'h1234;
        tick;
        load_digits = 16'hABCD;
        chk("t4_ready_low", {31'h0, load_ready}, 32'h0);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            tick;
            if (acc_cnt == base + 2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("t4_accept");
        load_valid = 1'b0;
        frame_start;
        check_frame("t4", 16'h7BDE, SEG_ABCD, 4'hF);

        // 5. blank and decimal point
        wait_ready;
        load_valid = 1'b1; load_digits = 16'h1234; load_blank = 4'b0100; load_dp = 4'b0001;
        tick;
        load_valid = 1'b0; load_blank = 4'h0; load_dp = 4'h0;
        frame_start;
        check_frame("t5", 16'h7FDE,
                    {7'b1111001, 7'b1111111, 7'b0110000, 7'b0011001}, 4'b1110);

        // 6. mid-frame reset discards pending load
        wait_ready;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if ((t % FR) == 0) begin
                ok = 1;
                break;
            end
            tick;
        end
        if (!ok) timeout("t6_align");
        load_valid = 1'b1; load_digits = 16'h9999; load_blank = 4'h0; load_dp = 4'hF;
        tick;
        load_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (((t / RD) % 4) == 2) begin
                ok = 1;
                break;
            end
            tick;
        end
        if (!ok) timeout("t6_idx2");
        rst = 1'b1;
        tick;
        chk("t6_an", {28'h0, an}, 32'hF);
        chk("t6_ready", {31'h0, load_ready}, 32'h1);
        rst = 1'b0;
        repeat (2) check_frame("t6_dark", 16'hFFFF, SEG_DARK, 4'hF);

        // random traffic with occasional reset
        base = acc_cnt;
        for (int c = 0; c < 1500; c++) begin
            tick;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                load_valid = 1'b0;
            end else if (load_valid && acc_cnt != base) begin
                load_valid = 1'b0;
            end else if (!load_valid && $urandom_range(0, 5) == 0) begin
                load_digits = 16'($urandom);
                load_blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                load_dp     = 4'($urandom);
                load_valid  = 1'b1;
                base = acc_cnt;
            end
        end
        rst = 1'b0;
        load_valid = 1'b0;
        repeat (4) tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
